alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 3-bit ALU function units (add, and the other ops selected by `op`). It accepts operation requests from two independent masters, grants one at a time, and drives the ALU's `op`/`en`/`A`/`B` inputs for exactly one cycle. It captures the registered 6-bit ALU result and returns it to the granted master with a one-cycle `done` pulse.

## Interface
- Parameters: none. Widths are fixed at 3-bit operands, 2-bit op and 6-bit result to match the ALU.
- `clk` input 1: single clock. All state updates on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req0`, `req1` input 1 each: request level from master 0 / master 1.
- `op0`, `op1` input 2 each: ALU op code (`2'b10` = add). Passed through uninterpreted.
- `a0`, `b0`, `a1`, `b1` input 3 each: operands.
- `done0`, `done1` output 1 each: one-cycle completion pulse to master 0 / master 1.
- `dout` output 6: captured result, valid while either `done` is high, held otherwise.
- `cout` output 1: equals `dout[3]`, the carry of a 3+3-bit add.
- `busy` output 1: high in every state except IDLE.
- `alu_en` output 1: ALU enable.
- `alu_op` output 2: ALU op select.
- `alu_a`, `alu_b` output 3 each: ALU operands.
- `alu_dout` input 6: ALU registered result.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when any request is high.
  - ISSUE → WAIT unconditionally.
  - WAIT → DONE unconditionally.
  - DONE → IDLE unconditionally.
- Grant in IDLE:
  - If only one request is high, that master wins.
  - If both are high, the master indicated by round-robin pointer `rr` wins.
  - `rr` updates to the non-winner on the IDLE→ISSUE edge.
- Request latching: on the IDLE→ISSUE edge, the winner's op/a/b and the grant id are latched internally. Later changes on the master inputs do not affect the operation in flight.
- ISSUE: `alu_en`=1, and `alu_op`/`alu_a`/`alu_b` are driven from the latched values. The ALU registers its result on the ISSUE→WAIT edge.
- WAIT: `alu_en`=0. `alu_dout` is sampled into `dout` on the WAIT→DONE edge.
- DONE: `done<grant>`=1 for exactly one cycle. The other `done` stays 0.
- Outside ISSUE, `alu_en`=0 and `alu_op`/`alu_a`/`alu_b` hold their last driven values (0 after reset).
- Master handshake:
  - A master holds `req` high until it sees its `done`.
  - If `req` is still high in the IDLE cycle after DONE, it is a new request.
  - Masters may change operands only after `done`.
- Request withdrawn mid-operation (`req` drops after grant): the operation still completes, and `done` still pulses.
- Fairness: with both requests held high continuously, grants alternate 0,1,0,1,… and each master waits at most one operation.
- Reset (any state, async):
  - State → IDLE, `rr` → 0, latched grant → 0.
  - All outputs → 0: `busy`, `done0`, `done1`, `dout`, `cout`, `alu_en`, `alu_op`, `alu_a`, `alu_b`.
  - An operation in flight is discarded with no `done`.

## Timing
- Request sampled at edge E0 in IDLE: ISSUE during cycle E0–E1, WAIT during E1–E2, DONE during E2–E3, back in IDLE after E3.
- Latency from sampling edge to `done` rising is 2 cycles. `done` lasts 1 cycle.
- Throughput: one operation per 4 cycles. IDLE always occupies at least one cycle between operations.
- `alu_en` high exactly 1 cycle per operation.
- `dout`/`cout` change only on the WAIT→DONE edge and at reset.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT with `alu_dout`=6'h0F → all outputs 0 immediately, state IDLE. No `done` follows after release.
- Single request: `req0`=1, `op0`=2'b10, `a0`=3, `b0`=4, behavioural ALU model → `alu_en` one cycle with `alu_a`=3, `alu_b`=4, `alu_op`=2'b10. Two cycles after the sampling edge, `done0`=1, `dout`=6'd7, `cout`=0.
- Carry: `req1`, add `a1`=7, `b1`=7 → `done1`=1, `dout`=6'd14, `cout`=1. `done0` stays 0.
- Contention: `req0`=`req1`=1 held for 4 operations from reset → grant order 0,1,0,1, with `done` pulses alternating every 4 cycles.
- Operand stability: change `a0` from 3 to 5 during ISSUE/WAIT → `dout` reflects `a0`=3.
- Withdrawal: drop `req1` during WAIT → `done1` still pulses in DONE. Next IDLE makes no grant unless a request is high.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-master round-robin arbiter that sequences one operation at a time onto the
// shared 3-bit ALU and returns the registered 6-bit result with a done pulse.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] op0,
    input  logic [1:0] op1,
    input  logic [2:0] a0,
    input  logic [2:0] b0,
    input  logic [2:0] a1,
    input  logic [2:0] b1,
    output logic       done0,
    output logic       done1,
    output logic [5:0] dout,
    output logic       cout,
    output logic       busy,
    output logic       alu_en,
    output logic [1:0] alu_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    input  logic [5:0] alu_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e     state_q, state_d;
    logic       rr_q, rr_d;
    logic       gnt_q, gnt_d;
    logic [1:0] op_q, op_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [5:0] dout_q, dout_d;
    logic       winner;

    // A lone requester always wins; the pointer only breaks ties.
    assign winner = (req0 && req1) ? rr_q : req1;

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        dout_d  = dout_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_ISSUE;
                    gnt_d   = winner;
                    rr_d    = ~winner;
                    op_d    = winner ? op1 : op0;
                    a_d     = winner ? a1  : a0;
                    b_d     = winner ? b1  : b0;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_DONE;
                dout_d  = alu_dout;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
        end
    end

    // Latched operands only change on entry to ISSUE, so they double as the held ALU inputs.
    assign alu_en = (state_q == S_ISSUE);
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign busy   = (state_q != S_IDLE);
    assign done0  = (state_q == S_DONE) && !gnt_q;
    assign done1  = (state_q == S_DONE) &&  gnt_q;
    assign dout   = dout_q;
    assign cout   = dout_q[3];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU feeds the DUT and a scoreboard
// queue of expected (grant, result) pairs is checked on every done pulse.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [2:0] a0, b0, a1, b1;
    logic       done0, done1, cout, busy, alu_en;
    logic [5:0] dout, alu_dout;
    logic [1:0] alu_op;
    logic [2:0] alu_a, alu_b;

    logic [5:0] alu_q;
    logic       alu_force;

    typedef struct packed {
        logic       gnt;
        logic [5:0] res;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .dout(dout), .cout(cout), .busy(busy),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_dout(alu_dout)
    );

    function automatic logic [5:0] alu_f(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        case (op)
            2'b00:   alu_f = {3'b000, a & b};
            2'b01:   alu_f = {3'b000, a | b};
            2'b10:   alu_f = {3'b000, a} + {3'b000, b};
            default: alu_f = {3'b000, a ^ b};
        endcase
    endfunction

    always @(posedge clk) if (alu_en) alu_q <= alu_f(alu_op, alu_a, alu_b);
    assign alu_dout = alu_force ? 6'h0F : alu_q;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic g, input logic [5:0] r);
        exp_t e;
        e.gnt = g;
        e.res = r;
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (done0 || done1)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_id", {6'd0, done1, done0}, e.gnt ? 8'd2 : 8'd1);
                check("dout", {2'b00, dout}, {2'b00, e.res});
                check("cout", {7'd0, cout}, {7'd0, e.res[3]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_r;
        logic       g;
        rst_n = 1'b0; alu_force = 1'b0; alu_q = '0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #12;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_dout", {2'b00, dout}, 8'd0);
        check("rst_alu_en", {7'd0, alu_en}, 8'd0);
        rst_n = 1'b1;
        cyc();

        // Single request from master 0: 3 + 4
        req0 = 1; op0 = 2'b10; a0 = 3; b0 = 4;
        push(1'b0, 6'd7);
        cyc();
        check("s_alu_en", {7'd0, alu_en}, 8'd1);
        check("s_alu_a", {5'd0, alu_a}, 8'd3);
        check("s_alu_b", {5'd0, alu_b}, 8'd4);
        check("s_alu_op", {6'd0, alu_op}, 8'd2);
        check("s_busy", {7'd0, busy}, 8'd1);
        cyc();
        check("s_wait_en", {7'd0, alu_en}, 8'd0);
        check("s_wait_done", {6'd0, done1, done0}, 8'd0);
        cyc();
        check("s_done0", {7'd0, done0}, 8'd1);
        req0 = 0;
        cyc();
        check("s_idle_busy", {7'd0, busy}, 8'd0);
        check("s_done_once", {6'd0, done1, done0}, 8'd0);
        check("s_dout_hold", {2'b00, dout}, 8'd7);

        // Carry from master 1: 7 + 7
        req1 = 1; op1 = 2'b10; a1 = 7; b1 = 7;
        push(1'b1, 6'd14);
        cyc(); cyc(); cyc();
        check("c_done1", {6'd0, done1, done0}, 8'd2);
        check("c_cout", {7'd0, cout}, 8'd1);
        req1 = 0;
        cyc();

        // Operands change while in flight; result must use the latched a0 = 3
        req0 = 1; op0 = 2'b10; a0 = 3; b0 = 1;
        push(1'b0, 6'd4);
        cyc();
        a0 = 5;
        cyc();
        a0 = 6; op0 = 2'b00;
        check("st_alu_a_hold", {5'd0, alu_a}, 8'd3);
        cyc();
        check("st_done0", {7'd0, done0}, 8'd1);
        req0 = 0;
        cyc();

        // Master 1 withdraws during WAIT; done still pulses, then no new grant
        req1 = 1; op1 = 2'b11; a1 = 5; b1 = 3;
        push(1'b1, 6'd6);
        cyc();
        cyc();
        req1 = 0;
        cyc();
        check("w_done1", {7'd0, done1}, 8'd1);
        cyc();
        cyc();
        check("w_no_grant", {6'd0, busy, alu_en}, 8'd0);
        cyc();

        // Reset mid-WAIT with a poisoned ALU result: operation discarded
        req0 = 1; op0 = 2'b10; a0 = 2; b0 = 2;
        cyc();
        cyc();
        alu_force = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("r_busy", {7'd0, busy}, 8'd0);
        check("r_done", {6'd0, done1, done0}, 8'd0);
        check("r_dout", {2'b00, dout}, 8'd0);
        check("r_cout", {7'd0, cout}, 8'd0);
        check("r_alu_en", {7'd0, alu_en}, 8'd0);
        check("r_alu_op", {6'd0, alu_op}, 8'd0);
        check("r_alu_ab", {2'b00, alu_a, alu_b}, 8'd0);
        req0 = 0;
        alu_force = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        check("r_stay_idle", {6'd0, busy, done0 | done1}, 8'd0);

        // Contention from reset: grants must go 0,1,0,1
        req0 = 1; op0 = 2'b10; a0 = 1; b0 = 2;
        req1 = 1; op1 = 2'b01; a1 = 6; b1 = 1;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            exp_r = g ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
            push(g, exp_r);
            cyc();
            check("ct_alu_en", {7'd0, alu_en}, 8'd1);
            check("ct_alu_a", {5'd0, alu_a}, g ? {5'd0, a1} : {5'd0, a0});
            check("ct_alu_op", {6'd0, alu_op}, g ? {6'd0, op1} : {6'd0, op0});
            cyc();
            cyc();
            check("ct_done", {6'd0, done1, done0}, g ? 8'd2 : 8'd1);
            if (g) begin
                a1 = a1 - 3'd2; op1 = 2'b11;
            end else begin
                a0 = a0 + 3'd4; op0 = 2'b00; b0 = 3'd7;
            end
            cyc();
            check("ct_idle", {7'd0, busy}, 8'd0);
        end
        req0 = 0; req1 = 0;
        cyc(); cyc(); cyc();
        check("sb_empty", sb_q.size() > 255 ? 8'hFF : 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
